id_wb_stage: RTL and testbench

- Parametrised ID→WB pipeline stage register for the pipelined processor.
- Carries operand A/B, destination register, immediate and status (register write enable) from decode to writeback.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and operand-forwarding compare outputs.
- Adds a saturating stall-cycle counter for performance debug.

---
 rtl/id_wb_stage_pkg.sv | 23 ++
 rtl/id_wb_stage_skid_buf2.sv | 63 ++++++
 rtl/id_wb_stage.sv | 68 ++++++
 tb/tb_id_wb_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/id_wb_stage_pkg.sv
// rtl/id_wb_stage_pkg.sv - shared widths and payload type for the ID->WB stage
package id_wb_stage_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REG_AW = 3;
    localparam int DEF_IMM_W  = 3;
    localparam int DEF_CNT_W  = 16;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data_a;
        logic [DEF_DATA_W-1:0] data_b;
        logic [DEF_REG_AW-1:0] rdst;
        logic [DEF_IMM_W-1:0]  imm_data;
        logic                  status;
    } stage_payload_t;

    localparam int DEF_PAYLOAD_W = $bits(stage_payload_t);

    function automatic int payload_w(int data_w, int reg_aw, int imm_w);
        return 2 * data_w + reg_aw + imm_w + 1;
    endfunction

endpackage

// File: rtl/id_wb_stage_skid_buf2.sv
// rtl/id_wb_stage_skid_buf2.sv - generic 2-entry valid/ready skid buffer with flush
module skid_buf2 #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_v;
    logic         skid_v;
    logic         accept;
    logic         pop;

    // skid_v implies main_v, so in_ready is a pure register output
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign occ       = {skid_v, main_v & ~skid_v};
    assign accept    = in_valid && !skid_v;
    assign pop       = main_v && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (pop) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (main_v) begin
            if (pop && accept) begin
                main_q <= in_data;
            end else if (pop) begin
                main_v <= 1'b0;
            end else if (accept) begin
                skid_q <= in_data;
                skid_v <= 1'b1;
            end
        end else if (accept) begin
            main_q <= in_data;
            main_v <= 1'b1;
        end
    end

endmodule

// File: rtl/id_wb_stage.sv
// rtl/id_wb_stage.sv - ID->WB pipeline register with skid buffer, forwarding compares, stall counter
module id_wb_stage
    import id_wb_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [REG_AW-1:0] rdst,
    input  logic [IMM_W-1:0]  imm_data,
    input  logic              status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_a_out,
    output logic [DATA_W-1:0] data_b_out,
    output logic [REG_AW-1:0] rdst_out,
    output logic [IMM_W-1:0]  imm_data_out,
    output logic              status_1,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rs_b,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = payload_w(DATA_W, REG_AW, IMM_W);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] head_payload;

    assign in_payload = {data_a, data_b, rdst, imm_data, status};
    assign {data_a_out, data_b_out, rdst_out, imm_data_out, status_1} = head_payload;

    skid_buf2 #(.W(PW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_payload),
        .occ       (occ)
    );

    assign fwd_a = out_valid && status_1 && (rdst_out == rs_a);
    assign fwd_b = out_valid && status_1 && (rdst_out == rs_b);

    // saturating so long stalls read as "at least max" rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_wb_stage.sv
// tb/tb_id_wb_stage.sv - directed self-checking bench for id_wb_stage
module tb_id_wb_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic [2:0] rdst = '0;
    logic [2:0] imm_data = '0;
    logic       status = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] data_a_out;
    logic [7:0] data_b_out;
    logic [2:0] rdst_out;
    logic [2:0] imm_data_out;
    logic       status_1;
    logic [2:0] rs_a = '0;
    logic [2:0] rs_b = '0;
    logic       fwd_a;
    logic       fwd_b;
    logic [1:0] occ;
    logic [3:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    id_wb_stage #(.DATA_W(8), .REG_AW(3), .IMM_W(3), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_a       (data_a),
        .data_b       (data_b),
        .rdst         (rdst),
        .imm_data     (imm_data),
        .status       (status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_a_out   (data_a_out),
        .data_b_out   (data_b_out),
        .rdst_out     (rdst_out),
        .imm_data_out (imm_data_out),
        .status_1     (status_1),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .occ          (occ),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        step();
        reset = 1'b0;

        // 1: reset mid-stream at occ=2
        in_valid = 1'b1; data_a = 8'hAA; step();
        data_a = 8'hBB; step();
        in_valid = 1'b0;
        check("t1_occ2", 32'(occ), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("t1_async_out_valid", 32'(out_valid), 32'd0);
        check("t1_async_data_a", 32'(data_a_out), 32'd0);
        check("t1_async_occ", 32'(occ), 32'd0);
        check("t1_async_in_ready", 32'(in_ready), 32'd1);
        check("t1_async_stall", 32'(stall_cnt), 32'd0);
        step();
        reset = 1'b0;
        in_valid = 1'b1; data_a = 8'h3C; out_ready = 1'b1;
        step();
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(data_a_out), 32'h3C);

        // 2: streaming at one per cycle
        for (int i = 1; i <= 10; i++) begin
            data_a = 8'(i);
            step();
            check($sformatf("t2_data_%0d", i), 32'(data_a_out), 32'(i));
            check($sformatf("t2_occ_%0d", i), 32'(occ), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("t2_drained", 32'(out_valid), 32'd0);

        // 3: backpressure, no loss, in order
        out_ready = 1'b0; in_valid = 1'b1;
        data_a = 8'h11; step();
        data_a = 8'h22; step();
        check("t3_occ", 32'(occ), 32'd2);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        data_a = 8'h33; step();
        check("t3_head_11", 32'(data_a_out), 32'h11);
        check("t3_occ_hold", 32'(occ), 32'd2);
        check("t3_stall", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        step();
        check("t3_head_22", 32'(data_a_out), 32'h22);
        check("t3_ready_back", 32'(in_ready), 32'd1);
        step();
        check("t3_head_33", 32'(data_a_out), 32'h33);
        in_valid = 1'b0;
        step();
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4: flush at occ=2 with concurrent input
        out_ready = 1'b0; in_valid = 1'b1;
        data_a = 8'h55; step();
        data_a = 8'h66; step();
        check("t4_occ2", 32'(occ), 32'd2);
        data_a = 8'h44; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_occ", 32'(occ), 32'd0);
        check("t4_payload", 32'(data_a_out), 32'd0);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_stall_kept", 32'(stall_cnt), 32'd4);
        step();
        check("t4_no_44", 32'(out_valid), 32'd0);

        // 5: forwarding compares
        in_valid = 1'b1; data_a = 8'h77; rdst = 3'd5; status = 1'b1;
        step();
        in_valid = 1'b0;
        rs_a = 3'd5; rs_b = 3'd2;
        #1;
        check("t5_fwd_a", 32'(fwd_a), 32'd1);
        check("t5_fwd_b", 32'(fwd_b), 32'd0);
        rs_b = 3'd5;
        #1;
        check("t5_fwd_b_hit", 32'(fwd_b), 32'd1);
        out_ready = 1'b1;
        step();
        check("t5_fwd_a_empty", 32'(fwd_a), 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; status = 1'b0; data_a = 8'h78;
        step();
        in_valid = 1'b0;
        rs_b = 3'd2;
        #1;
        check("t5_rdst", 32'(rdst_out), 32'd5);
        check("t5_fwd_a_nowe", 32'(fwd_a), 32'd0);
        check("t5_fwd_b_nowe", 32'(fwd_b), 32'd0);

        // 6: stall counter saturation (CNT_W=4), head held stable
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 10) check("t6_reach15", 32'(stall_cnt), 32'd15);
        end
        check("t6_sat", 32'(stall_cnt), 32'd15);
        check("t6_stable", 32'(data_a_out), 32'h78);
        check("t6_valid", 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
